down_counter: RTL and testbench

Loadable down counter, the count-down counterpart of the team's free-running 4-bit up counter. Loads a start value, decrements once per enabled clock, and flags terminal count with a single-cycle pulse. In one-shot mode it stops at zero; in auto-reload mode it restarts from the last loaded value, giving a programmable periodic tick. Used as the timeout/interval source next to the up counter in the same clock domain.

---
 rtl/down_counter.sv | 85 ++++++++
 tb/tb_down_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Loadable down counter with a one-shot or auto-reload terminal-count pulse.
// Every output is registered; the next-state logic is in one always_comb block.
module down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] counter,
    output logic             zero,
    output logic             tc_pulse,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             zero_q, zero_d;
    logic             tc_pulse_q, tc_pulse_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        reload_d   = reload_q;
        tc_pulse_d = 1'b0;

        if (load) begin
            // A load restarts immediately and drops any terminal count due on this edge.
            counter_d = load_value;
            reload_d  = load_value;
            state_d   = (load_value != '0) ? RUN : IDLE;
        end else if (state_q == RUN && enable) begin
            if (counter_q == ONE) begin
                tc_pulse_d = 1'b1;
                if (auto_reload) begin
                    counter_d = reload_q;
                end else begin
                    counter_d = '0;
                    state_d   = IDLE;
                end
            end else begin
                counter_d = counter_q - ONE;
            end
        end

        // Status flags are derived from next-state values so they stay in step with counter.
        zero_d = (counter_d == '0);
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            reload_q   <= '0;
            zero_q     <= 1'b1;
            tc_pulse_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            reload_q   <= reload_d;
            zero_q     <= zero_d;
            tc_pulse_q <= tc_pulse_d;
            busy_q     <= busy_d;
        end
    end

    assign counter  = counter_q;
    assign zero     = zero_q;
    assign tc_pulse = tc_pulse_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: directed vectors push hand-computed
// expected outputs, and a monitor pops and compares them after each clock edge.
module tb_down_counter;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             enable = 1'b0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] counter;
    logic             zero;
    logic             tc_pulse;
    logic             busy;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] cnt;
        logic             z;
        logic             tc;
        logic             b;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .auto_reload(auto_reload),
        .counter    (counter),
        .zero       (zero),
        .tc_pulse   (tc_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic drv(input string name, input logic rst, input logic ld, input int lv,
                       input logic en, input logic ar, input int ec, input logic ez,
                       input logic et, input logic eb);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        load        = ld;
        load_value  = WIDTH'(lv);
        enable      = en;
        auto_reload = ar;
        e.name = name;
        e.cnt  = WIDTH'(ec);
        e.z    = ez;
        e.tc   = et;
        e.b    = eb;
        sb.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (counter !== e.cnt || zero !== e.z || tc_pulse !== e.tc || busy !== e.b) begin
                    errors++;
                    $display("FAIL %s: got cnt=%0d zero=%b tc=%b busy=%b, expected cnt=%0d zero=%b tc=%b busy=%b",
                             e.name, counter, zero, tc_pulse, busy, e.cnt, e.z, e.tc, e.b);
                end
            end
        end
    end

    initial begin
        // reset state
        drv("reset", 1, 0, 0, 1, 0, 0, 1, 0, 0);
        drv("reset2", 1, 1, 9, 1, 1, 0, 1, 0, 0);

        // one-shot from 5
        drv("os_load5", 0, 1, 5, 1, 0, 5, 0, 0, 1);
        drv("os_4", 0, 0, 0, 1, 0, 4, 0, 0, 1);
        drv("os_3", 0, 0, 0, 1, 0, 3, 0, 0, 1);
        drv("os_2", 0, 0, 0, 1, 0, 2, 0, 0, 1);
        drv("os_1", 0, 0, 0, 1, 0, 1, 0, 0, 1);
        drv("os_tc", 0, 0, 0, 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) drv("os_stay0", 0, 0, 0, 1, 1, 0, 1, 0, 0);

        // auto-reload period 3, four pulses in 12 cycles
        drv("ar_load3", 0, 1, 3, 1, 1, 3, 0, 0, 1);
        for (int p = 0; p < 4; p++) begin
            drv("ar_2", 0, 0, 0, 1, 1, 2, 0, 0, 1);
            drv("ar_1", 0, 0, 0, 1, 1, 1, 0, 0, 1);
            drv("ar_tc", 0, 0, 0, 1, 1, 3, 0, 1, 1);
        end
        drv("ar_load0", 0, 1, 0, 1, 1, 0, 1, 0, 0);
        drv("idle_en", 0, 0, 0, 1, 1, 0, 1, 0, 0);

        // enable toggling, pulse 7 cycles after load
        drv("tog_load4", 0, 1, 4, 0, 0, 4, 0, 0, 1);
        drv("tog_e1", 0, 0, 0, 1, 0, 3, 0, 0, 1);
        drv("tog_h1", 0, 0, 0, 0, 0, 3, 0, 0, 1);
        drv("tog_e2", 0, 0, 0, 1, 0, 2, 0, 0, 1);
        drv("tog_h2", 0, 0, 0, 0, 0, 2, 0, 0, 1);
        drv("tog_e3", 0, 0, 0, 1, 0, 1, 0, 0, 1);
        drv("tog_h3", 0, 0, 0, 0, 0, 1, 0, 0, 1);
        drv("tog_tc", 0, 0, 0, 1, 0, 0, 1, 1, 0);

        // reload mid-count
        drv("rl_load6", 0, 1, 6, 1, 0, 6, 0, 0, 1);
        drv("rl_5", 0, 0, 0, 1, 0, 5, 0, 0, 1);
        drv("rl_4", 0, 0, 0, 1, 0, 4, 0, 0, 1);
        drv("rl_load2", 0, 1, 2, 1, 0, 2, 0, 0, 1);
        drv("rl_1", 0, 0, 0, 1, 0, 1, 0, 0, 1);
        drv("rl_tc", 0, 0, 0, 1, 0, 0, 1, 1, 0);

        // load on the terminal edge wins, no pulse
        drv("lt_load2", 0, 1, 2, 1, 0, 2, 0, 0, 1);
        drv("lt_1", 0, 0, 0, 1, 0, 1, 0, 0, 1);
        drv("lt_load3", 0, 1, 3, 1, 0, 3, 0, 0, 1);

        // auto_reload only matters at the terminal edge
        drv("arm_load2", 0, 1, 2, 1, 0, 2, 0, 0, 1);
        drv("arm_1", 0, 0, 0, 1, 1, 1, 0, 0, 1);
        drv("arm_tc", 0, 0, 0, 1, 0, 0, 1, 1, 0);

        // reload value 1: pulse every cycle
        drv("one_load1", 0, 1, 1, 1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) drv("one_tc", 0, 0, 0, 1, 1, 1, 0, 1, 1);
        drv("one_hold", 0, 0, 0, 0, 1, 1, 0, 0, 1);
        drv("one_load0", 0, 1, 0, 1, 1, 0, 1, 0, 0);
        drv("one_idle", 0, 0, 0, 1, 1, 0, 1, 0, 0);

        // full-scale load 15
        drv("fs_load15", 0, 1, 15, 1, 0, 15, 0, 0, 1);
        for (int i = 14; i >= 1; i--) drv("fs_cnt", 0, 0, 0, 1, 0, i, 0, 0, 1);
        drv("fs_tc", 0, 0, 0, 1, 0, 0, 1, 1, 0);

        // reset beats load mid-count
        drv("rs_load9", 0, 1, 9, 1, 0, 9, 0, 0, 1);
        for (int i = 8; i >= 2; i--) drv("rs_cnt", 0, 0, 0, 1, 0, i, 0, 0, 1);
        drv("rs_reset_load", 1, 1, 7, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drv("rs_after", 0, 0, 0, 1, 1, 0, 1, 0, 0);

        // reset suppresses a due pulse
        drv("rp_load1", 0, 1, 1, 1, 1, 1, 0, 0, 1);
        drv("rp_reset", 1, 0, 0, 1, 1, 0, 1, 0, 0);

        @(negedge clk);
        reset  = 1'b0;
        load   = 1'b0;
        enable = 1'b0;
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
